// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor gate-drive stage.
// coil_sel_t is common with the upstream commutation block.
package mtr_pkg;

   localparam int          PWM_W       = 11;
   localparam logic [10:0] PERIOD_LAST = 11'h7FF;

   typedef enum logic [1:0] {
      HIGH_Z   = 2'b00,
      REV_CURR = 2'b01,
      FOR_CURR = 2'b10,
      REGEN    = 2'b11
   } coil_sel_t;

   typedef enum logic {
      IDLE   = 1'b0,
      DEAD_T = 1'b1
   } nov_state_t;

   // Returns {high_req, low_req} for one phase.
   function automatic logic [1:0] gate_req(input coil_sel_t sel, input logic pwm);
      logic [1:0] req;
      req = 2'b00;
      case (sel)
         HIGH_Z:   req = 2'b00;
         REV_CURR: req = {~pwm, pwm};
         FOR_CURR: req = {pwm, ~pwm};
         REGEN:    req = {1'b0, pwm};
         default:  req = 2'b00;
      endcase
      return req;
   endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// Duty/select inputs and gate-drive outputs of the motor drive stage.
// master = upstream/commutation side, slave = mtr_drv.
interface mtr_drv_if;
   logic [10:0] duty;
   logic [1:0]  selGrn;
   logic [1:0]  selYlw;
   logic [1:0]  selBlu;
   logic        PWM_synch;
   logic        highGrn;
   logic        lowGrn;
   logic        highYlw;
   logic        lowYlw;
   logic        highBlu;
   logic        lowBlu;

   modport master (
      output duty, selGrn, selYlw, selBlu,
      input  PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu
   );

   modport slave (
      input  duty, selGrn, selYlw, selBlu,
      output PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu
   );
endinterface

// File: rtl/mtr_drv_nonoverlap.sv
// One phase of dead-time insertion: any change of the requested gate pair
// holds both switches off for DEAD cycles before the new pair is applied.
module nonoverlap
   import mtr_pkg::*;
#(
   parameter int DEAD = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic high_req,
   input  logic low_req,
   output logic high_out,
   output logic low_out
);

   localparam logic [7:0] DEAD_LD = 8'(DEAD);

   nov_state_t state_q, state_d;
   logic [1:0] prev_q, prev_d;
   logic [7:0] dcnt_q, dcnt_d;
   logic [1:0] out_q, out_d;
   logic [1:0] req;
   logic [1:0] prev_legal;

   assign req        = {high_req, low_req};
   // A pair with both switches on is never passed through.
   assign prev_legal = (prev_q == 2'b11) ? 2'b00 : prev_q;

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      dcnt_d  = dcnt_q;
      out_d   = out_q;
      if (req != prev_q) begin
         prev_d  = req;
         state_d = DEAD_T;
         dcnt_d  = DEAD_LD;
         out_d   = 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               out_d = prev_legal;
            end
            DEAD_T: begin
               if (dcnt_q <= 8'd1) begin
                  state_d = IDLE;
                  dcnt_d  = 8'd0;
                  out_d   = prev_legal;
               end else begin
                  dcnt_d = dcnt_q - 8'd1;
                  out_d  = 2'b00;
               end
            end
            default: begin
               state_d = IDLE;
               out_d   = 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prev_q  <= 2'b00;
         dcnt_q  <= 8'd0;
         out_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         dcnt_q  <= dcnt_d;
         out_q   <= out_d;
      end
   end

   assign high_out = out_q[1];
   assign low_out  = out_q[0];

endmodule

// File: rtl/mtr_drv.sv
// Motor gate-drive stage: free-running 11-bit PWM with period-aligned duty,
// end-of-period synch strobe, per-phase select decode and dead-time channels.
module mtr_drv
   import mtr_pkg::*;
#(
   parameter int DEAD = 32
) (
   input  logic       clk,
   input  logic       rst,
   mtr_drv_if.slave   bus
);

   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             synch_q, synch_d;

   always_comb begin
      cnt_d   = cnt_q + 11'd1;
      duty_d  = duty_q;
      // Duty only moves at the period boundary so each period is one clean pulse.
      if (cnt_q == PERIOD_LAST) begin
         duty_d = bus.duty;
      end
      pwm_d   = (cnt_q < duty_q);
      synch_d = (cnt_q == PERIOD_LAST - 11'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
         synch_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         synch_q <= synch_d;
      end
   end

   assign bus.PWM_synch = synch_q;

   // Phase order: 0 = green, 1 = yellow, 2 = blue.
   logic [1:0] sel_arr [3];
   logic [2:0] high_out;
   logic [2:0] low_out;

   assign sel_arr[0] = bus.selGrn;
   assign sel_arr[1] = bus.selYlw;
   assign sel_arr[2] = bus.selBlu;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_phase
         logic [1:0] req;
         assign req = gate_req(coil_sel_t'(sel_arr[gi]), pwm_q);

         nonoverlap #(
            .DEAD (DEAD)
         ) u_nov (
            .clk      (clk),
            .rst      (rst),
            .high_req (req[1]),
            .low_req  (req[0]),
            .high_out (high_out[gi]),
            .low_out  (low_out[gi])
         );
      end
   endgenerate

   assign bus.highGrn = high_out[0];
   assign bus.lowGrn  = low_out[0];
   assign bus.highYlw = high_out[1];
   assign bus.lowYlw  = low_out[1];
   assign bus.highBlu = high_out[2];
   assign bus.lowBlu  = low_out[2];

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: per-cycle comparison against a
// request-history model plus literal pulse-width and timing expectations.
module tb_mtr_drv;

   localparam int DEAD = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mtr_drv_if bus();

   mtr_drv #(.DEAD(DEAD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Gate pair applied in a cycle = last sampled request, provided the request
   // has been identical for the last DEAD+1 samples; otherwise both off.
   int          m_cnt;
   logic [10:0] m_duty;
   logic        m_pwm;
   logic        m_synch;
   logic [1:0]  hist [3][DEAD+1];
   logic [1:0]  s_sel [3];
   logic [10:0] s_duty;
   logic        s_rst = 1'b1;

   function automatic logic [1:0] req_of(input logic [1:0] sel, input logic pwm);
      case (sel)
         2'b00:   return 2'b00;
         2'b01:   return {~pwm, pwm};
         2'b10:   return {pwm, ~pwm};
         default: return {1'b0, pwm};
      endcase
   endfunction

   always @(negedge clk) begin
      logic [1:0] exp_g [3];
      logic [6:0] exp_v;
      logic [6:0] act_v;
      logic       same;
      int         overlap;
      if (rst || s_rst) begin
         m_cnt = 0; m_duty = '0; m_pwm = 1'b0; m_synch = 1'b0;
         for (int p = 0; p < 3; p++)
            for (int k = 0; k <= DEAD; k++) hist[p][k] = 2'b00;
      end else begin
         for (int p = 0; p < 3; p++) begin
            for (int k = DEAD; k > 0; k--) hist[p][k] = hist[p][k-1];
            hist[p][0] = req_of(s_sel[p], m_pwm);
         end
         m_synch = (m_cnt == 2046);
         m_pwm   = (m_cnt < int'(m_duty));
         if (m_cnt == 2047) m_duty = s_duty;
         m_cnt = (m_cnt + 1) % 2048;
      end
      for (int p = 0; p < 3; p++) begin
         same = 1'b1;
         for (int k = 1; k <= DEAD; k++) if (hist[p][k] != hist[p][0]) same = 1'b0;
         exp_g[p] = (same && hist[p][0] != 2'b11) ? hist[p][0] : 2'b00;
      end
      exp_v = {m_synch, exp_g[0], exp_g[1], exp_g[2]};
      act_v = {bus.PWM_synch, bus.highGrn, bus.lowGrn, bus.highYlw, bus.lowYlw,
               bus.highBlu, bus.lowBlu};
      check("cycle_outputs", int'(act_v), int'(exp_v));
      overlap = int'(bus.highGrn & bus.lowGrn) + int'(bus.highYlw & bus.lowYlw)
              + int'(bus.highBlu & bus.lowBlu);
      check("no_shoot_through", overlap, 0);
      s_sel[0] = bus.selGrn; s_sel[1] = bus.selYlw; s_sel[2] = bus.selBlu;
      s_duty   = bus.duty;
      s_rst    = rst;
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic [10:0] d, input logic [1:0] g,
                         input logic [1:0] y, input logic [1:0] b);
      bus.duty = d; bus.selGrn = g; bus.selYlw = y; bus.selBlu = b;
   endtask

   task automatic sync_wait();
      int n;
      n = 0;
      while (n < 2100) begin
         @(posedge clk); #1;
         n++;
         if (bus.PWM_synch) break;
      end
      if (n >= 2100) check("synch_timeout", 0, 1);
   endtask

   // One full period window, cnt 0..0x7FF, optionally changing duty at cnt==chg_at.
   task automatic measure(input int chg_at, input logic [10:0] newd,
                          output int hg, output int lg, output int hy, output int ly,
                          output int hb, output int lb, output int sy);
      hg = 0; lg = 0; hy = 0; ly = 0; hb = 0; lb = 0; sy = 0;
      for (int i = 0; i < 2048; i++) begin
         @(posedge clk); #1;
         if (i == chg_at) bus.duty = newd;
         hg += int'(bus.highGrn); lg += int'(bus.lowGrn);
         hy += int'(bus.highYlw); ly += int'(bus.lowYlw);
         hb += int'(bus.highBlu); lb += int'(bus.lowBlu);
         sy += int'(bus.PWM_synch);
      end
   endtask

   task automatic count_first_synch(input string name);
      int n;
      n = 0;
      while (n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (bus.PWM_synch) break;
      end
      // cnt reaches 0x7FF after 2047 rising edges, i.e. clock cycle 2048.
      check(name, n, 2047);
   endtask

   int hg, lg, hy, ly, hb, lb, sy, n;

   initial begin
      set_in(11'h000, 2'b00, 2'b00, 2'b00);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({bus.PWM_synch, bus.highGrn, bus.lowGrn, bus.highYlw,
                                   bus.lowYlw, bus.highBlu, bus.lowBlu}), 0);
      rst = 1'b0;
      count_first_synch("first_synch_after_reset");

      // 50% duty, green forward
      set_in(11'h400, 2'b10, 2'b00, 2'b00);
      sync_wait();
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      check("d400_highGrn", hg, 992);
      check("d400_lowGrn", lg, 992);
      check("d400_ylw_blu", hy + ly + hb + lb, 0);
      check("d400_synch_per_period", sy, 1);

      // braking on all phases
      set_in(11'h600, 2'b11, 2'b11, 2'b11);
      sync_wait();
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      check("brake_high_gates", hg + hy + hb, 0);
      check("brake_lowGrn", lg, 1504);
      check("brake_lowYlw", ly, 1504);
      check("brake_lowBlu", lb, 1504);

      // mid-period duty change takes effect only next period
      set_in(11'h200, 2'b10, 2'b00, 2'b00);
      sync_wait();
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      measure(11'h100, 11'h500, hg, lg, hy, ly, hb, lb, sy);
      check("chg_current_period_high", hg, 512 - DEAD);
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      check("chg_next_period_high", hg, 1280 - DEAD);

      // duty 0: low side continuously on
      set_in(11'h000, 2'b10, 2'b00, 2'b00);
      sync_wait();
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      check("d0_highGrn", hg, 0);
      check("d0_lowGrn", lg, 2048);

      // duty max: single low slot swallowed by dead time, 33 cycles all off
      set_in(11'h7FF, 2'b10, 2'b00, 2'b00);
      sync_wait();
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      measure(-1, 11'h0, hg, lg, hy, ly, hb, lb, sy);
      check("d7ff_highGrn", hg, 2048 - 33);
      check("d7ff_lowGrn", lg, 0);

      // select swap on yellow with pwm held low
      set_in(11'h000, 2'b00, 2'b10, 2'b00);
      sync_wait();
      repeat (2100) @(posedge clk);
      #1;
      check("ylw_low_settled", int'(bus.lowYlw), 1);
      bus.selYlw = 2'b01;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (bus.highYlw) break;
         n++;
      end
      check("ylw_swap_dead_cycles", n, DEAD);
      bus.selYlw = 2'b10;
      repeat (40) @(posedge clk);
      #1;
      bus.selYlw = 2'b01;
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         n += int'(!bus.highYlw && !bus.lowYlw);
      end
      bus.selYlw = 2'b10;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (bus.lowYlw) break;
         n++;
      end
      check("ylw_restart_dead_cycles", n, 10 + DEAD);

      // asynchronous reset while the green high side is on
      set_in(11'h400, 2'b10, 2'b00, 2'b00);
      n = 0;
      while (!bus.highGrn && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check("highGrn_before_reset", int'(bus.highGrn), 1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs", int'({bus.PWM_synch, bus.highGrn, bus.lowGrn, bus.highYlw,
                                         bus.lowYlw, bus.highBlu, bus.lowBlu}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_first_synch("first_synch_after_async_reset");

      // randomized duty/select traffic, one random reset pulse
      for (int i = 0; i < 12000; i++) begin
         @(posedge clk); #1;
         if (i == 6000) rst = 1'b1;
         if (i == 6003) rst = 1'b0;
         if ($urandom_range(0, 999) == 0) bus.duty = 11'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            case ($urandom_range(0, 2))
               0:       bus.selGrn = 2'($urandom);
               1:       bus.selYlw = 2'($urandom);
               default: bus.selBlu = 2'($urandom);
            endcase
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Downstream stage of the commutation block. It consumes the 11-bit duty and the three 2-bit per-phase coil selects.
- It produces the six gate-drive signals (high/low per phase) with dead-time insertion.
- It generates the PWM_synch strobe that the commutation block uses to sample the Hall sensors.
- It contains an 11-bit free-running PWM counter, a period-aligned duty latch, and three non-overlap channels.

Parameters:
- DEAD, 32, dead-time in clk cycles during which both switches of a phase are held off after any gate request change; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- duty  in  11  requested PWM duty, 0..0x7FF
- selGrn  in  2  green coil select: 00 HIGH_Z, 01 rev_curr, 10 for_curr, 11 regen_braking
- selYlw  in  2  yellow coil select, same encoding
- selBlu  in  2  blue coil select, same encoding
- PWM_synch  out  1  one-clk strobe at end of each PWM period
- highGrn  out  1  green high-side gate
- lowGrn  out  1  green low-side gate
- highYlw  out  1  yellow high-side gate
- lowYlw  out  1  yellow low-side gate
- highBlu  out  1  blue high-side gate
- lowBlu  out  1  blue low-side gate

Behaviour:
- Reset (async, rst=1): cnt=0, duty_r=0, pwm_r=0, PWM_synch=0, all six gate outputs 0, all dead counters 0. Outputs go 0 immediately, independent of clk.
- Counter: cnt is 11-bit and increments every clk. It wraps 0x7FF->0x000. Period is 2048 clk.
- Duty latch: duty_r <= duty only in the cycle where cnt==0x7FF. A mid-period duty change has no effect until the next period.
- PWM:
  - pwm_r <= (cnt < duty_r), unsigned compare; registered, one clk latency.
  - duty_r=0 gives pwm_r constantly 0.
  - duty_r=0x7FF gives pwm_r high 2047 of 2048 cycles; it is never 100%.
- PWM_synch: registered; PWM_synch <= (cnt==0x7FE). It is therefore high exactly in the cycle cnt==0x7FF, once per period, never two consecutive cycles.
- Gate request per phase, combinational from sel and pwm_r:
  - 00 HIGH_Z: high_req=0, low_req=0.
  - 01 rev_curr: high_req=~pwm_r, low_req=pwm_r.
  - 10 for_curr: high_req=pwm_r, low_req=~pwm_r.
  - 11 regen_braking: high_req=0, low_req=pwm_r.
- Non-overlap channel (one per phase):
  - States IDLE / DEAD_T.
  - It holds prev_h/prev_l, the last sampled requests.
  - If {high_req,low_req} != {prev_h,prev_l} in cycle N:
    - Capture the new requests, enter DEAD_T, load the dead counter, and drive both outputs 0 from cycle N+1.
    - Outputs stay 0 for DEAD cycles (N+1..N+DEAD).
    - At N+DEAD+1 the outputs take the captured requests and the channel returns to IDLE.
  - A further request change while in DEAD_T restarts the full dead interval.
  - If high_req and low_req are both 1 (illegal), both outputs are forced 0 regardless of state.
  - In IDLE with no change, outputs = prev values.
  - The channel's prev_h/prev_l, dead counter and state reset to 0/IDLE.
- Invariant: highX and lowX are never both 1 in any cycle, including during reset release and select changes.
- Select inputs are used unregistered. They are already stable per period because the upstream block only updates on PWM_synch, but the dead-time logic covers any change regardless.

Decomposition:
- Shared package mtr_pkg:
  - coil_sel_t enum {HIGH_Z=2'b00, REV_CURR=2'b01, FOR_CURR=2'b10, REGEN=2'b11}, common with the commutation block.
  - PWM_W=11.
  - PERIOD_LAST=11'h7FF.
- Sub-module nonoverlap, parameterized by DEAD:
  - Inputs clk, rst, high_req, low_req; outputs high_out, low_out.
  - Instantiated three times.
- The top holds the counter, duty latch, PWM compare, synch generation and the select decode.

Test Plan:
- Reset: assert rst mid-operation with highGrn=1 -> all gate outputs and PWM_synch drop to 0 asynchronously. After release, the first PWM_synch appears at clk 2048 (cnt==0x7FF).
- duty=0x400, selGrn=10, others 00:
  - Over a steady period, highGrn=1 for 1024-DEAD=992 cycles and lowGrn=1 for 1024-DEAD=992 cycles.
  - Each switch edge is separated by 32 cycles with both low.
  - Yellow and blue gates stay 0.
- duty=0x600, all sel=11 (braking) -> high gates 0 throughout. Each low gate is high 1536-DEAD=1504 cycles per period, with a 32-cycle off gap after each pwm edge.
- Duty change mid-period: duty 0x200 -> 0x500 at cnt=0x100 -> the current period's pwm high time stays 512 cycles. The next period, which starts after PWM_synch, shows 1280.
- Select change and illegal request:
  - selYlw 10->01 at arbitrary cnt -> both yellow gates 0 for exactly 32 cycles, then the swapped pattern.
  - A second change within the dead window restarts the 32-cycle count.
  - Assertion checks high&low never both 1 for all phases.
- duty=0 with sel=10 -> highGrn=0, lowGrn=1 continuously after the initial 32-cycle dead time. duty=0x7FF -> the low gate pulses only where the 1-cycle low pwm slot exists, and that pulse is suppressed by the dead time (both gates 0 for those 33 cycles).
